// File: rtl/bus_latch_pkg.sv
// Shared constants and helpers for the bus latch queue and its strobe synchroniser.
package bus_latch_pkg;

  localparam int SYNC_STAGES     = 2;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_RESET_VALUE = 1;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous strobe into clk and emits a one-cycle pulse
// on each synchronised rising edge. A level held high yields a single pulse.
module sync_edge_detect
  import bus_latch_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic pulse_o
);

  // sync_q[STAGES-1:0] is the synchroniser chain, sync_q[STAGES] is the
  // previous synchronised level used for edge detection.
  logic [STAGES:0] sync_q, sync_d;

  assign sync_d = {sync_q[STAGES-1:0], async_i};

  // Shift the strobe through the chain; reset clears every stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign pulse_o = sync_q[STAGES-1] & ~sync_q[STAGES];

endmodule

// File: rtl/bus_latch_queue.sv
// Clocked queue replacing the transparent bus latch between the 68000 bus
// and the graphics controller. Words are captured on latchenable strobes,
// drained in order by pop, and the head (or last popped word) drives out.
// Optional macro LATCH_TRANSPARENT_EN: while empty, a raw high latchenable
// passes in straight through to out, as the legacy latch did.
module bus_latch_queue
  import bus_latch_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int          DEPTH       = DEF_DEPTH,
  parameter logic [31:0] RESET_VALUE = DEF_RESET_VALUE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in,
  input  logic                          latchenable,
  input  logic                          outputenable,
  input  logic                          pop,
  input  logic                          clr_ovf,
  output wire logic [WIDTH-1:0]         out,
  output logic                          empty,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow
);

  localparam int                AW       = $clog2(DEPTH);
  localparam int                CW       = cnt_width(DEPTH);
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0]  RST_WORD = RESET_VALUE[WIDTH-1:0];

  logic             push;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop, drop;
  logic [WIDTH-1:0] reg_head, head;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_le_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .async_i (latchenable),
    .pulse_o (push)
  );

  // Flags are decoded from the registered count only.
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign overflow = ovf_q;

  // Next-state for pointers, occupancy, hold register and sticky overflow.
  // A pop on a full queue frees the slot the coincident push needs.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    drop     = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  // Control state register; reset discards queued words via the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= RST_WORD;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
    end
  end

  // Queue storage; contents need no reset since the pointers gate access.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in;
  end

  // Head word when occupied, otherwise the last popped word.
  always_comb begin
    reg_head = empty ? hold_q : mem_q[rd_ptr_q];
  end

`ifdef LATCH_TRANSPARENT_EN
  assign head = (empty && latchenable) ? in : reg_head;
`else
  assign head = reg_head;
`endif

  assign out = outputenable ? {WIDTH{1'bz}} : head;

endmodule

// File: tb/tb_bus_latch_queue.sv
// Scoreboard bench for bus_latch_queue: strobes push expected words into a
// queue model, a monitor pops and compares on every accepted pop.
module tb_bus_latch_queue;
  import bus_latch_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset, le, oe, pop, clr;
  logic [W-1:0]  din;
  tri1  [W-1:0]  dout;
  logic          empty, full, ovf;
  logic [CW-1:0] count;

  int            n_chk = 0;
  int            n_err = 0;
  logic [W-1:0]  sb_q[$];
  logic [W-1:0]  hold_exp;
  bit            ovf_exp;

  always #5 clk = ~clk;

  bus_latch_queue #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(1)) dut (
    .clk(clk), .reset(reset), .in(din), .latchenable(le), .outputenable(oe),
    .pop(pop), .clr_ovf(clr), .out(dout), .empty(empty), .full(full),
    .count(count), .overflow(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every pop on a non-empty model must present the oldest word.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (!reset && pop) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pop_head", dout, e);
        hold_exp = e;
      end else begin
        chk("pop_on_empty_flag", empty, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk); #1;
    chk({tag, ":count"}, count, sb_q.size());
    chk({tag, ":empty"}, empty, sb_q.size() == 0);
    chk({tag, ":full"},  full,  sb_q.size() == D);
    chk({tag, ":ovf"},   ovf,   ovf_exp);
    chk({tag, ":out"},   dout,  (sb_q.size() > 0) ? sb_q[0] : hold_exp);
    @(posedge clk); #1;
  endtask

  // Raise latchenable with data d for 'hold' cycles, then keep d stable a bit longer.
  task automatic strobe(input logic [W-1:0] d, input int hold);
    din = d;
    le  = 1'b1;
    #1;
    if (sb_q.size() == 0) begin
`ifdef LATCH_TRANSPARENT_EN
      chk("transparent_out", dout, d);
`else
      chk("opaque_out", dout, hold_exp);
`endif
    end
    if (sb_q.size() < D) sb_q.push_back(d);
    else                 ovf_exp = 1'b1;
    repeat (hold) tick();
    le = 1'b0;
    repeat (3) tick();
    din = W'($urandom);
  endtask

  task automatic pop_op();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic clr_op();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ovf_exp = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    n_err++;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; le = 1'b0; oe = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
    hold_exp = 16'h0001; ovf_exp = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_state("reset");
    chk("reset_out_const", dout, 16'h0001);
    oe = 1'b1; #1;
    chk("hiz_out", dout, 16'hFFFF);
    oe = 1'b0; #1;
    chk("driven_again", dout, 16'h0001);
    tick();

    // Single word capture and pop into hold.
    strobe(16'hA5A5, 4);
    check_state("a5_push");
    pop_op();
    check_state("a5_pop");
    chk("a5_hold_const", dout, 16'hA5A5);

    // Fill, overflow, drain in order, clear overflow.
    for (int i = 1; i <= 4; i++) strobe(W'(i), 4);
    check_state("fill");
    strobe(16'h0005, 4);
    check_state("overflow");
    chk("ovf_const", ovf, 1);
    for (int i = 0; i < 4; i++) pop_op();
    check_state("drain");
    chk("drain_last_const", dout, 16'h0004);
    clr_op();
    check_state("clr_ovf");

    // Full queue with a pop coinciding with the synchronised push of BEEF.
    for (int i = 0; i < 4; i++) strobe(W'($urandom), 4);
    check_state("refill");
    din = 16'hBEEF; le = 1'b1;
    sb_q.push_back(16'hBEEF);
    tick(); tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick(); tick();
    le = 1'b0;
    repeat (3) tick();
    check_state("coincident");
    chk("coincident_full_const", full, 1);
    for (int i = 0; i < 4; i++) pop_op();
    check_state("beef_drain");
    chk("beef_hold_const", dout, 16'hBEEF);

    // Long level gives one push; pops on empty are ignored.
    strobe(W'($urandom), 10);
    check_state("long_level");
    pop_op();
    pop_op();
    check_state("pop_empty");
    chk("pop_empty_ovf", ovf, 0);

    // Reset with words queued.
    for (int i = 0; i < 3; i++) strobe(W'($urandom), 4);
    check_state("pre_reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    hold_exp = 16'h0001;
    ovf_exp  = 1'b0;
    check_state("mid_reset");
    chk("mid_reset_out_const", dout, 16'h0001);

    // Randomised mix of strobes, pops and overflow clears.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      strobe(W'($urandom), $urandom_range(4, 7));
      else if (r < 9) pop_op();
      else            clr_op();
      check_state("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
